// File: rtl/vga_timing_gen_if.sv
// vga_if: pixel-stream bundle carried from the timing generator through the draw stages
interface vga_if;
  logic [10:0] hcount;
  logic [10:0] vcount;
  logic        hsync;
  logic        vsync;
  logic        hblnk;
  logic        vblnk;
  logic [11:0] rgb;
  modport out (output hcount, vcount, hsync, vsync, hblnk, vblnk, rgb);
  modport in  (input  hcount, vcount, hsync, vsync, hblnk, vblnk, rgb);
endinterface

// File: rtl/vga_timing_gen.sv
// vga_timing_gen: source of the vga_if stream, one pixel per enabled clock with line/frame strobes
module vga_timing_gen #(
  parameter int   H_ACTIVE = 800,
  parameter int   H_FP     = 40,
  parameter int   H_SYNC   = 128,
  parameter int   H_BP     = 88,
  parameter int   V_ACTIVE = 600,
  parameter int   V_FP     = 1,
  parameter int   V_SYNC   = 4,
  parameter int   V_BP     = 23,
  parameter logic HS_POL   = 1'b1,
  parameter logic VS_POL   = 1'b1
) (
  input  logic clk,
  input  logic rst,
  input  logic pix_en,
  vga_if.out   out,
  output logic line_start,
  output logic frame_start
);
  localparam int H_TOTAL = H_ACTIVE + H_FP + H_SYNC + H_BP;
  localparam int V_TOTAL = V_ACTIVE + V_FP + V_SYNC + V_BP;
  localparam logic [10:0] H_LAST   = 11'(H_TOTAL - 1);
  localparam logic [10:0] V_LAST   = 11'(V_TOTAL - 1);
  localparam logic [10:0] H_ACT    = 11'(H_ACTIVE);
  localparam logic [10:0] V_ACT    = 11'(V_ACTIVE);
  localparam logic [10:0] HS_START = 11'(H_ACTIVE + H_FP);
  localparam logic [10:0] HS_END   = 11'(H_ACTIVE + H_FP + H_SYNC);
  localparam logic [10:0] VS_START = 11'(V_ACTIVE + V_FP);
  localparam logic [10:0] VS_END   = 11'(V_ACTIVE + V_FP + V_SYNC);
  if (H_TOTAL > 2048 || V_TOTAL > 2048) begin : g_bad_total
    $error("vga_timing_gen: H_TOTAL and V_TOTAL must not exceed 2048");
  end
  // Position of the pixel the next enabled cycle will present; the registered
  // outputs are decoded from it so every field describes the same pixel.
  logic [10:0] px_h;
  logic [10:0] px_v;
  logic        h_last;
  logic        v_last;
  assign h_last  = px_h == H_LAST;
  assign v_last  = px_v == V_LAST;
  assign out.rgb = 12'h000;
  // Present the pending pixel and advance the raster on each enabled cycle; strobes drop when stalled.
  always_ff @(posedge clk) begin
    if (rst) begin
      px_h        <= '0;
      px_v        <= '0;
      out.hcount  <= '0;
      out.vcount  <= '0;
      out.hblnk   <= 1'b0;
      out.vblnk   <= 1'b0;
      out.hsync   <= ~HS_POL;
      out.vsync   <= ~VS_POL;
      line_start  <= 1'b0;
      frame_start <= 1'b0;
    end else begin
      line_start  <= pix_en && px_h == '0;
      frame_start <= pix_en && px_h == '0 && px_v == '0;
      if (pix_en) begin
        out.hcount <= px_h;
        out.vcount <= px_v;
        out.hblnk  <= px_h >= H_ACT;
        out.vblnk  <= px_v >= V_ACT;
        out.hsync  <= (px_h >= HS_START && px_h < HS_END) ? HS_POL : ~HS_POL;
        out.vsync  <= (px_v >= VS_START && px_v < VS_END) ? VS_POL : ~VS_POL;
        px_h       <= h_last ? '0 : px_h + 11'd1;
        px_v       <= h_last ? (v_last ? '0 : px_v + 11'd1) : px_v;
      end
    end
  end
endmodule

// File: tb/tb_vga_timing_gen.sv
// tb_vga_timing_gen: directed + randomized checks of three generator instances against a raster model
module tb_vga_timing_gen;
  typedef struct packed {
    logic [10:0] h;
    logic [10:0] v;
    logic        hs;
    logic        vs;
    logic        hb;
    logic        vb;
    logic [11:0] rgb;
    logic        ls;
    logic        fs;
  } vo_t;
  logic clk = 1'b0;
  logic rst = 1'b1;
  logic pix_en = 1'b0;
  int total = 0;
  int bad = 0;
  int k = 0;
  logic last_en = 1'b0;
  vga_if ia ();
  vga_if ib ();
  vga_if ic ();
  logic ls_a, fs_a, ls_b, fs_b, ls_c, fs_c;
  vo_t oa, ob, oc;
  always #5 clk = ~clk;
  vga_timing_gen dut_a (.clk(clk), .rst(rst), .pix_en(pix_en), .out(ia), .line_start(ls_a), .frame_start(fs_a));
  vga_timing_gen #(.H_ACTIVE(16), .H_FP(4), .H_SYNC(8), .H_BP(4), .V_ACTIVE(12), .V_FP(1), .V_SYNC(2), .V_BP(3),
                   .HS_POL(1'b1), .VS_POL(1'b1))
    dut_b (.clk(clk), .rst(rst), .pix_en(pix_en), .out(ib), .line_start(ls_b), .frame_start(fs_b));
  vga_timing_gen #(.H_ACTIVE(16), .H_FP(4), .H_SYNC(8), .H_BP(4), .V_ACTIVE(12), .V_FP(1), .V_SYNC(2), .V_BP(3),
                   .HS_POL(1'b0), .VS_POL(1'b0))
    dut_c (.clk(clk), .rst(rst), .pix_en(pix_en), .out(ic), .line_start(ls_c), .frame_start(fs_c));
  assign oa = {ia.hcount, ia.vcount, ia.hsync, ia.vsync, ia.hblnk, ia.vblnk, ia.rgb, ls_a, fs_a};
  assign ob = {ib.hcount, ib.vcount, ib.hsync, ib.vsync, ib.hblnk, ib.vblnk, ib.rgb, ls_b, fs_b};
  assign oc = {ic.hcount, ic.vcount, ic.hsync, ic.vsync, ic.hblnk, ic.vblnk, ic.rgb, ls_c, fs_c};
  // Expected outputs after k enabled cycles since reset: pixel k-1 in raster order.
  function automatic vo_t model(int ha, int hf, int hs, int hb, int va, int vf, int vs, int vb, logic hp, logic vp);
    vo_t e;
    int ht, vt, h, v;
    e = '0;
    e.hs = ~hp;
    e.vs = ~vp;
    if (k == 0) return e;
    ht = ha + hf + hs + hb;
    vt = va + vf + vs + vb;
    h = (k - 1) % ht;
    v = ((k - 1) / ht) % vt;
    e.h = 11'(h);
    e.v = 11'(v);
    e.hb = h >= ha;
    e.vb = v >= va;
    e.hs = (h >= ha + hf && h < ha + hf + hs) ? hp : ~hp;
    e.vs = (v >= va + vf && v < va + vf + vs) ? vp : ~vp;
    e.ls = last_en && h == 0;
    e.fs = last_en && h == 0 && v == 0;
    return e;
  endfunction
  task automatic check_all();
    vo_t ea, eb, ec;
    ea = model(800, 40, 128, 88, 600, 1, 4, 23, 1'b1, 1'b1);
    eb = model(16, 4, 8, 4, 12, 1, 2, 3, 1'b1, 1'b1);
    ec = model(16, 4, 8, 4, 12, 1, 2, 3, 1'b0, 1'b0);
    total += 3;
    assert (oa === ea) else begin bad++; $error("FAIL cyc_a k=%0d got=%h exp=%h", k, oa, ea); end
    assert (ob === eb) else begin bad++; $error("FAIL cyc_b k=%0d got=%h exp=%h", k, ob, eb); end
    assert (oc === ec) else begin bad++; $error("FAIL cyc_c k=%0d got=%h exp=%h", k, oc, ec); end
  endtask
  task automatic step(input logic en, input logic r);
    pix_en = en;
    rst = r;
    @(posedge clk);
    if (r) begin
      k = 0;
      last_en = 1'b0;
    end else begin
      last_en = en;
      if (en) k++;
    end
    #1;
    check_all();
  endtask
  task automatic chk(input string tag, input int got, input int exp);
    total++;
    assert (got === exp) else begin bad++; $error("FAIL %s got=%0d exp=%0d", tag, got, exp); end
  endtask
  initial begin
    int hs_cnt, hs_first, hb_first, n, per, lsn, vbn, vsn, hlow;
    logic prev_ls;
    step(1'b0, 1'b1);
    chk("reset_a", int'(oa), 0);
    chk("reset_b", int'(ob), 0);
    chk("reset_c_sync", {ic.hsync, ic.vsync, 9'(ic.hcount)}, {2'b11, 9'd0});
    step(1'b1, 1'b0);
    chk("first_pix_a", {oa.h, oa.v, oa.hs, oa.vs, oa.hb, oa.vb, oa.ls, oa.fs}, {11'd0, 11'd0, 6'b000011});
    hs_cnt = 0;
    hs_first = -1;
    hb_first = -1;
    for (int i = 1; i < 1056; i++) begin
      step(1'b1, 1'b0);
      if (oa.hs) hs_cnt++;
      if (oa.hs && hs_first < 0) hs_first = int'(oa.h);
      if (oa.hb && hb_first < 0) hb_first = int'(oa.h);
    end
    chk("hsync_width_a", hs_cnt, 128);
    chk("hsync_first_a", hs_first, 840);
    chk("hblnk_first_a", hb_first, 800);
    chk("last_h_a", int'(oa.h), 1055);
    step(1'b1, 1'b0);
    chk("wrap_a", {oa.h, oa.v, oa.ls, oa.fs}, {11'd0, 11'd1, 2'b10});
    n = 0;
    while (!ob.fs && n < 2000) begin step(1'b1, 1'b0); n++; end
    chk("find_frame_b", int'(ob.fs), 1);
    per = 0; lsn = 0; vbn = 0; vsn = 0; hlow = 0;
    do begin
      step(1'b1, 1'b0);
      per++;
      if (ob.ls) lsn++;
      if (ob.ls && ob.vb) vbn++;
      if (ob.ls && ob.vs) vsn++;
      if (!oc.hs) hlow++;
    end while (!ob.fs && per < 2000);
    chk("frame_period_b", per, 576);
    chk("lines_per_frame_b", lsn, 18);
    chk("vblnk_lines_b", vbn, 6);
    chk("vsync_lines_b", vsn, 2);
    chk("hsync_low_c", hlow, 144);
    per = 0;
    prev_ls = ob.ls;
    do begin
      per++;
      step(per % 2 == 0, 1'b0);
      chk("strobe_width_b", int'(prev_ls && ob.ls), 0);
      prev_ls = ob.ls;
    end while (!ob.fs && per < 3000);
    chk("toggle_period_b", per, 1152);
    n = 0;
    while (!(ob.h == 11'd22 && ob.v == 11'd13) && n < 2000) begin step(1'b1, 1'b0); n++; end
    chk("mid_sync_b", {ob.hs, ob.vs, oc.hs, oc.vs}, 4'b1100);
    step(1'b1, 1'b1);
    chk("mid_reset_b", int'(ob), 0);
    chk("mid_reset_c", {oc.hs, oc.vs, oc.h, oc.v}, {2'b11, 22'd0});
    step(1'b1, 1'b0);
    chk("resume_b", {ob.h, ob.v, ob.hs, ob.vs, ob.ls, ob.fs}, {22'd0, 4'b0011});
    for (int i = 0; i < 20000; i++)
      step(($urandom % 4) != 0, ($urandom % 5000) == 0);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
